// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce / edge-detect block:
// per-channel FSM state encoding and a constant clog2 for counter sizing.
package debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debounce channel: two-state qualification FSM with a stability
// counter, registered level and rise/fall pulses, saturating edge counter.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 en,
  input  logic                 clear,
  output logic                 dout,
  output logic                 rise,
  output logic                 fall,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [CNT_WIDTH-1:0] glitch_cnt,
`endif
  output logic [CNT_WIDTH-1:0] edge_cnt
);

  localparam int unsigned    SW       = clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0]  CNT_LAST = SW'(DEBOUNCE_CNT - 1);

  state_t                 state, state_nxt;
  logic [SW-1:0]          cnt, cnt_nxt;
  logic                   dout_nxt, rise_nxt, fall_nxt;
  logic                   reject;
  logic [CNT_WIDTH-1:0]   edge_nxt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [CNT_WIDTH-1:0]   glitch_nxt;
`endif

  // Next-state, qualification and counter update logic.
  always_comb begin
    state_nxt = ST_STABLE;
    cnt_nxt   = '0;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    reject    = 1'b0;
    if (en) begin
      case (state)
        ST_STABLE: begin
          if (din != dout) begin
            state_nxt = ST_CHECK;
            cnt_nxt   = SW'(1);
          end
        end
        ST_CHECK: begin
          if (din == dout) begin
            reject = 1'b1;
          end else if (cnt == CNT_LAST) begin
            dout_nxt = din;
            rise_nxt = din;
            fall_nxt = ~din;
          end else begin
            state_nxt = ST_CHECK;
            cnt_nxt   = cnt + SW'(1);
          end
        end
      endcase
    end

    // Clear is applied before the increment so a coincident event yields 1.
    edge_nxt = clear ? '0 : edge_cnt;
    if (rise_nxt && (edge_nxt != '1))
      edge_nxt = edge_nxt + CNT_WIDTH'(1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    glitch_nxt = clear ? '0 : glitch_cnt;
    if (reject && (glitch_nxt != '1))
      glitch_nxt = glitch_nxt + CNT_WIDTH'(1);
`endif
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      dout       <= INIT_LEVEL;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_cnt <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dout       <= dout_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      edge_cnt   <= edge_nxt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_cnt <= glitch_nxt;
`endif
    end
  end

endmodule

// File: rtl/debounce_edge_detector.sv
// Multi-channel debounce and edge detector: parameter checks plus WIDTH
// independent debounce_channel instances with counter bus packing.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds the GLITCH_CNT output.
module debounce_edge_detector
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           IN,
  input  logic                       EN,
  input  logic                       CLEAR,
  output logic [WIDTH-1:0]           OUT,
  output logic [WIDTH-1:0]           RISE,
  output logic [WIDTH-1:0]           FALL,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [WIDTH*CNT_WIDTH-1:0] GLITCH_CNT,
`endif
  output logic [WIDTH*CNT_WIDTH-1:0] EDGE_CNT
);

  if (WIDTH < 1) begin : g_bad_width
    $error("debounce_edge_detector: WIDTH must be at least 1");
  end
  if (DEBOUNCE_CNT < 2 || DEBOUNCE_CNT > 65535) begin : g_bad_cnt
    $error("debounce_edge_detector: DEBOUNCE_CNT must be in 2..65535");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("debounce_edge_detector: CNT_WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CNT_WIDTH    (CNT_WIDTH),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_channel (
      .clk        (CLK),
      .rst        (RST),
      .din        (IN[i]),
      .en         (EN),
      .clear      (CLEAR),
      .dout       (OUT[i]),
      .rise       (RISE[i]),
      .fall       (FALL[i]),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .glitch_cnt (GLITCH_CNT[i*CNT_WIDTH +: CNT_WIDTH]),
`endif
      .edge_cnt   (EDGE_CNT[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Self-checking bench for debounce_edge_detector (WIDTH=2, DEBOUNCE_CNT=4,
// CNT_WIDTH=2). Vector table through a scoreboard queue, plus a hand-written
// asynchronous reset sequence. GLITCH_CNT is checked when
// DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_debounce_edge_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] din = 2'b11;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] dout, rise, fall;
  logic [3:0] ecnt;
  logic [3:0] gcnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] din;
    logic       en;
    logic       clr;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [3:0] ecnt;
    logic [3:0] gcnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  debounce_edge_detector #(
    .WIDTH        (2),
    .DEBOUNCE_CNT (4),
    .CNT_WIDTH    (2),
    .INIT_LEVEL   (1'b0)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .IN         (din),
    .EN         (en),
    .CLEAR      (clr),
    .OUT        (dout),
    .RISE       (rise),
    .FALL       (fall),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .GLITCH_CNT (gcnt),
`endif
    .EDGE_CNT   (ecnt)
  );

`ifndef DEBOUNCE_GLITCH_CNT_EN
  assign gcnt = '0;
`endif

  task automatic check(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] d, input logic e, input logic c,
                     input logic [1:0] o, input logic [1:0] r, input logic [1:0] f,
                     input logic [3:0] ec, input logic [3:0] gc);
    vec_t v;
    v.din = d; v.en = e; v.clr = c; v.dout = o; v.rise = r; v.fall = f;
    v.ecnt = ec; v.gcnt = gc;
    vecs.push_back(v);
  endtask

  // n cycles where no accepted transition is expected.
  task automatic hold(input int n, input logic [1:0] d, input logic e, input logic c,
                      input logic [1:0] o, input logic [3:0] ec, input logic [3:0] gc);
    for (int i = 0; i < n; i++) add(d, e, c, o, 2'b00, 2'b00, ec, gc);
  endtask

  // Called at a negedge; drives each vector, samples 1 time unit after the edge.
  task automatic run_vecs();
    vec_t exp;
    for (int i = 0; i < vecs.size(); i++) begin
      din = vecs[i].din;
      en  = vecs[i].en;
      clr = vecs[i].clr;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check("out",      i, {2'b00, dout}, {2'b00, exp.dout});
      check("rise",     i, {2'b00, rise}, {2'b00, exp.rise});
      check("fall",     i, {2'b00, fall}, {2'b00, exp.fall});
      check("edge_cnt", i, ecnt, exp.ecnt);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch_cnt", i, gcnt, exp.gcnt);
`endif
      @(negedge clk);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset held with IN high: outputs stay at the reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  -1, {2'b00, dout}, 4'b0000);
    check("rst_rise", -1, {2'b00, rise}, 4'b0000);
    check("rst_fall", -1, {2'b00, fall}, 4'b0000);
    check("rst_edge", -1, ecnt, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Basic rise on ch0 after 4 samples.
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0000, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0001, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0000);
    // Glitch on ch1: 3 samples then back.
    hold(3, 2'b11, 1, 0, 2'b01, 4'b0001, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0100);
    // Fall on ch0.
    hold(3, 2'b00, 1, 0, 2'b01, 4'b0001, 4'b0100);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 4'b0001, 4'b0100);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 4'b0001, 4'b0100);
    // Simultaneous rise then fall on both channels.
    hold(3, 2'b11, 1, 0, 2'b00, 4'b0001, 4'b0100);
    add (2'b11, 1, 0, 2'b11, 2'b11, 2'b00, 4'b0110, 4'b0100);
    hold(3, 2'b00, 1, 0, 2'b11, 4'b0110, 4'b0100);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b11, 4'b0110, 4'b0100);
    // ch0 rises 3..5: counter saturates at 3.
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0110, 4'b0100);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0111, 4'b0100);
    hold(3, 2'b00, 1, 0, 2'b01, 4'b0111, 4'b0100);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 4'b0111, 4'b0100);
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0111, 4'b0100);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0111, 4'b0100);
    hold(3, 2'b00, 1, 0, 2'b01, 4'b0111, 4'b0100);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 4'b0111, 4'b0100);
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0111, 4'b0100);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0111, 4'b0100);
    // CLEAR alone, then CLEAR coincident with a ch1 rise.
    add (2'b01, 1, 1, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0000);
    hold(3, 2'b11, 1, 0, 2'b01, 4'b0000, 4'b0000);
    add (2'b11, 1, 1, 2'b11, 2'b10, 2'b00, 4'b0100, 4'b0000);
    hold(3, 2'b00, 1, 0, 2'b11, 4'b0100, 4'b0000);
    add (2'b00, 1, 0, 2'b00, 2'b00, 2'b11, 4'b0100, 4'b0000);
    // EN dropped after 2 CHECK cycles; CLEAR still works while disabled.
    hold(2, 2'b01, 1, 0, 2'b00, 4'b0100, 4'b0000);
    hold(2, 2'b01, 0, 0, 2'b00, 4'b0100, 4'b0000);
    add (2'b01, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000);
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0000, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0001, 4'b0000);
    run_vecs();

    // Asynchronous reset in the middle of a CHECK on ch0.
    din = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out",  -2, {2'b00, dout}, 4'b0000);
    check("async_rst_rise", -2, {2'b00, rise}, 4'b0000);
    check("async_rst_fall", -2, {2'b00, fall}, 4'b0000);
    check("async_rst_edge", -2, ecnt, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Qualification after reset starts from zero.
    hold(3, 2'b01, 1, 0, 2'b00, 4'b0000, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 4'b0001, 4'b0000);
    add (2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0000);
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge_detector.md
Name: debounce_edge_detector

Overview:
Multi-channel debounce and edge-detect stage. It sits directly downstream of the three-stage synchronizer and consumes its already-synchronized outputs. Each bit is qualified by a per-channel stability counter, and the block produces a clean level, single-cycle rise/fall pulses and a saturating rising-edge counter. Typical use: mechanical inputs, trigger/veto lines and slow status flags feeding register-file logic.

Parameters:
WIDTH, 1, number of independent channels
DEBOUNCE_CNT, 16, consecutive identical samples required to accept a new level; legal range 2..65535
CNT_WIDTH, 16, width of each per-channel rising-edge counter
INIT_LEVEL, 1'b0, reset value of every OUT bit and of the internal accepted level

Ports:
CLK  input  1  single clock; all logic on posedge
RST  input  1  asynchronous, active-high reset
IN  input  WIDTH  synchronized input levels from the synchronizer; not re-synchronized here
EN  input  1  global enable; low freezes qualification
CLEAR  input  1  synchronous clear of all EDGE_CNT fields
OUT  output  WIDTH  debounced level, registered
RISE  output  WIDTH  one-cycle pulse on an accepted 0->1 transition
FALL  output  WIDTH  one-cycle pulse on an accepted 1->0 transition
EDGE_CNT  output  WIDTH*CNT_WIDTH  per-channel accepted-rise count; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-qualification):
  - OUT = INIT_LEVEL; RISE = FALL = 0; EDGE_CNT = 0.
  - Every channel FSM enters STABLE with its stability counter at 0.
- Per-channel FSM, two states:
  - STABLE: if EN and IN != OUT -> go to CHECK, cnt = 1. Otherwise stay, cnt = 0.
  - CHECK, IN == OUT: return to STABLE, cnt = 0. The glitch is rejected and no pulse is produced.
  - CHECK, IN != OUT and cnt == DEBOUNCE_CNT-1: OUT <= IN, pulse RISE or FALL for exactly one cycle, go to STABLE, cnt = 0.
  - CHECK, IN != OUT otherwise: cnt++.
- Latency: IN first sampled different at edge k and held through edge k+DEBOUNCE_CNT-1 -> OUT changes after edge k+DEBOUNCE_CNT-1. RISE/FALL are asserted in the same cycle that OUT first shows the new value.
- Stability counter width: clog2(DEBOUNCE_CNT). It never wraps.
- EN low:
  - All channels are forced to STABLE with cnt = 0.
  - OUT is frozen, no pulses are produced, EDGE_CNT holds, CLEAR still works.
  - When EN rises again, qualification restarts from zero.
- EDGE_CNT:
  - Increments by 1 on each RISE and saturates at all-ones; there is no wrap.
  - CLEAR and RISE in the same cycle -> result is 1 (clear first, then count).
  - CLEAR alone -> 0.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Outputs are registered only; there is no combinational path from IN to any output.

Optional Feature:
Macro DEBOUNCE_GLITCH_CNT_EN.
- Defined: adds output GLITCH_CNT, WIDTH*CNT_WIDTH bits.
  - Increments each time a channel leaves CHECK via a glitch rejection (IN returns to OUT before acceptance).
  - Saturating; cleared by RST and CLEAR.
  - Same CLEAR/increment priority as EDGE_CNT: simultaneous -> 1.
- Undefined: the port and its counters are absent; all other behaviour is identical.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding localparams ST_STABLE = 1'b0, ST_CHECK = 1'b1;
  - a constant clog2 function for counter sizing.
- One sub-module, debounce_channel: single-bit FSM, stability counter, OUT/RISE/FALL and the saturating counter(s). It is instantiated WIDTH times by a generate loop in the top level.
- The top level only does parameter checks and EDGE_CNT/GLITCH_CNT bus packing.

Test Plan:
1. Basic rise (DEBOUNCE_CNT=4, WIDTH=1): hold RST=1 with IN=1 -> OUT=0, RISE=0, EDGE_CNT=0. Release RST, keep IN=1 for 4 edges -> OUT=1 after the 4th edge, RISE high for exactly that cycle, EDGE_CNT=1.
2. Glitch rejection: OUT=0; IN=1 for 3 cycles then 0 -> OUT stays 0, no RISE, EDGE_CNT unchanged; GLITCH_CNT=1 if the macro is defined.
3. Falling edge: OUT=1; IN=0 for 4 cycles -> OUT=0, one FALL pulse, EDGE_CNT unchanged.
4. Saturation (CNT_WIDTH=2): 5 accepted rises -> EDGE_CNT=3 after the 3rd rise and stays 3.
5. CLEAR: CLEAR coincident with a RISE -> EDGE_CNT=1. CLEAR alone -> EDGE_CNT=0.
6. EN and reset mid-operation:
   - EN dropped after 2 CHECK cycles, then restored with IN still 1 -> OUT rises only after 4 further samples.
   - RST pulsed mid-CHECK -> immediate return to INIT_LEVEL, pulses 0.
